// File: rtl/reg_bus_pkg.sv
// Shared types and helpers for the register-bus arbiter.
package reg_bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StRdWait
  } state_e;

  localparam int unsigned DefAddrWidth = 8;
  localparam int unsigned DefDataWidth = 16;
  localparam int unsigned MaxReq       = 8;

  // Index of the set bit in a one-hot vector (0 when no bit is set).
  function automatic logic [2:0] onehot_to_idx(input logic [MaxReq-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MaxReq; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first pending request at or after ptr, wrapping.
module rr_arbiter
  import reg_bus_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IdxW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdxW-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IdxW-1:0]    idx,
  output logic [IdxW-1:0]    next_ptr
);

  logic            found;
  logic [IdxW-1:0] cand;

  // Scan from ptr upward; the first pending candidate wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IdxW'((32'(ptr) + i) % NUM_REQ);
      if (en && req[cand] && !found) begin
        gnt[cand] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  // Winner index and the pointer position just past it.
  always_comb begin
    idx      = IdxW'(onehot_to_idx(MaxReq'(gnt)));
    next_ptr = (idx == IdxW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Shares one register-control target port among NUM_REQ requesters.
module reg_bus_arbiter
  import reg_bus_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_gnt,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          m_sel,
  output logic                          m_wr,
  output logic [ADDR_WIDTH-1:0]         m_addr,
  output logic [DATA_WIDTH-1:0]         m_wdata,
  input  logic [DATA_WIDTH-1:0]         m_rdata,
  input  logic                          m_ready
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         ptr_q, ptr_d;
  logic [IdxW-1:0]         owner_q, owner_d;
  logic                    m_sel_q, m_sel_d;
  logic                    m_wr_q, m_wr_d;
  logic [ADDR_WIDTH-1:0]   m_addr_q, m_addr_d;
  logic [DATA_WIDTH-1:0]   m_wdata_q, m_wdata_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic                    accept;
  logic                    arb_en;
  logic [NUM_REQ-1:0]      arb_gnt;
  logic [IdxW-1:0]         arb_idx;
  logic [IdxW-1:0]         arb_next;
  logic                    load;

  assign accept = m_sel_q & m_ready;

  // Grants only from idle or on a write accept; never while a command or read is pending.
  always_comb begin
    arb_en = rstn && ((state_q == StIdle) || ((state_q == StCmd) && accept && m_wr_q));
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IdxW    (IdxW)
  ) u_rr_arbiter (
    .req      (req_valid),
    .ptr      (ptr_q),
    .en       (arb_en),
    .gnt      (arb_gnt),
    .idx      (arb_idx),
    .next_ptr (arb_next)
  );

  // Next-state: sequencing FSM plus command/response register loads.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    m_sel_d     = m_sel_q;
    m_wr_d      = m_wr_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    load        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|arb_gnt) begin
          load    = 1'b1;
          state_d = StCmd;
        end
      end
      StCmd: begin
        if (accept) begin
          if (m_wr_q) begin
            if (|arb_gnt) begin
              load = 1'b1;
            end else begin
              m_sel_d = 1'b0;
              state_d = StIdle;
            end
          end else begin
            // Select stays up one more cycle; target data arrives now.
            state_d = StRdWait;
          end
        end
      end
      StRdWait: begin
        rsp_rdata_d          = m_rdata;
        rsp_valid_d[owner_q] = 1'b1;
        m_sel_d              = 1'b0;
        state_d              = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      m_sel_d   = 1'b1;
      m_wr_d    = req_wr[arb_idx];
      m_addr_d  = req_addr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      m_wdata_d = req_wdata[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
      owner_d   = arb_idx;
      ptr_d     = arb_next;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      owner_q     <= '0;
      m_sel_q     <= 1'b0;
      m_wr_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      m_sel_q     <= m_sel_d;
      m_wr_q      <= m_wr_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_gnt   = arb_gnt;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign m_sel     = m_sel_q;
  assign m_wr      = m_wr_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed testbench for reg_bus_arbiter (4 requesters, 8-bit addr, 16-bit data).
module tb_reg_bus_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  logic            clk;
  logic            rstn;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_wr;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_gnt;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            m_sel;
  logic            m_wr;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [DW-1:0]   m_rdata;
  logic            m_ready;

  int checks   = 0;
  int failures = 0;

  // Target model: accept counter, last write, read data one cycle after accept.
  int            acc_cnt = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;

  reg_bus_arbiter #(
    .NUM_REQ    (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_gnt   (req_gnt),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .m_sel     (m_sel),
    .m_wr      (m_wr),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .m_ready   (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_sel && m_ready) begin
      acc_cnt <= acc_cnt + 1;
      if (m_wr) begin
        wr_addr <= m_addr;
        wr_data <= m_wdata;
      end else begin
        m_rdata <= (m_addr == 8'h10) ? 16'hBEEF : {8'h00, m_addr};
      end
    end
  end

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_wr[i]            = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic default_reqs();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'(8'h20 + i), 16'(16'h1000 + i));
  endtask

  task automatic apply_reset();
    rstn      = 1'b0;
    req_valid = '0;
    m_ready   = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn      = 1'b0;
    req_valid = 4'hF;
    m_ready   = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (m_sel !== 1'b0) begin failures++; $display("FAIL reset_m_sel got=%b exp=0", m_sel); end
    checks++; if (req_gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", req_gnt); end
    checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
    checks++; if (m_addr !== 8'h00) begin failures++; $display("FAIL reset_m_addr got=%h exp=00", m_addr); end
    checks++; if (rsp_rdata !== 16'h0000) begin failures++; $display("FAIL reset_rsp_rdata got=%h exp=0000", rsp_rdata); end
    rstn = 1'b1;
    #1;
    checks++; if (req_gnt !== 4'b0001) begin failures++; $display("FAIL reset_first_gnt got=%b exp=0001", req_gnt); end
    @(negedge clk);
    req_valid = '0;
    checks++; if (m_sel !== 1'b1 || m_addr !== 8'h20) begin failures++; $display("FAIL reset_first_cmd got=%b/%h exp=1/20", m_sel, m_addr); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_gnt;
    apply_reset();
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      exp_gnt = 4'(1 << (k % 4));
      checks++; if (req_gnt !== exp_gnt) begin failures++; $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, req_gnt, exp_gnt); end
      @(negedge clk);
      checks++;
      if (m_sel !== 1'b1 || m_wr !== 1'b1 || m_addr !== 8'(8'h20 + k % 4) || m_wdata !== 16'(16'h1000 + k % 4)) begin
        failures++;
        $display("FAIL rr_cmd k=%0d got=%b/%b/%h/%h exp=1/1/%h/%h", k, m_sel, m_wr, m_addr, m_wdata,
                 8'(8'h20 + k % 4), 16'(16'h1000 + k % 4));
      end
    end
    req_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_read();
    apply_reset();
    set_req(2, 1'b0, 8'h10, 16'h0000);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_gnt !== 4'b0100) begin failures++; $display("FAIL rd_gnt got=%b exp=0100", req_gnt); end
    @(negedge clk);
    req_valid = '0;
    checks++; if (m_sel !== 1'b1 || m_wr !== 1'b0 || m_addr !== 8'h10) begin failures++; $display("FAIL rd_cmd got=%b/%b/%h exp=1/0/10", m_sel, m_wr, m_addr); end
    @(negedge clk);
    checks++; if (m_sel !== 1'b1 || m_addr !== 8'h10 || rsp_valid !== 4'b0000) begin failures++; $display("FAIL rd_wait got=%b/%h/%b exp=1/10/0000", m_sel, m_addr, rsp_valid); end
    @(negedge clk);
    checks++; if (rsp_valid !== 4'b0100) begin failures++; $display("FAIL rd_rsp_valid got=%b exp=0100", rsp_valid); end
    checks++; if (rsp_rdata !== 16'hBEEF) begin failures++; $display("FAIL rd_rsp_rdata got=%h exp=beef", rsp_rdata); end
    checks++; if (m_sel !== 1'b0) begin failures++; $display("FAIL rd_sel_drop got=%b exp=0", m_sel); end
    @(negedge clk);
    checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL rd_rsp_pulse got=%b exp=0000", rsp_valid); end
    default_reqs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read_then_write();
    apply_reset();
    set_req(0, 1'b0, 8'h10, 16'h0000);
    set_req(1, 1'b1, 8'h30, 16'h5A5A);
    req_valid = 4'b0011;
    #1;
    checks++; if (req_gnt !== 4'b0001) begin failures++; $display("FAIL rw_gnt0 got=%b exp=0001", req_gnt); end
    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    checks++; if (req_gnt !== 4'b0000) begin failures++; $display("FAIL rw_no_gnt_accept got=%b exp=0000", req_gnt); end
    @(negedge clk);
    #1;
    checks++; if (req_gnt !== 4'b0000) begin failures++; $display("FAIL rw_no_gnt_rdwait got=%b exp=0000", req_gnt); end
    @(negedge clk);
    #1;
    checks++; if (req_gnt !== 4'b0010) begin failures++; $display("FAIL rw_gnt1 got=%b exp=0010", req_gnt); end
    checks++; if (rsp_valid !== 4'b0001) begin failures++; $display("FAIL rw_rsp got=%b exp=0001", rsp_valid); end
    @(negedge clk);
    req_valid = '0;
    checks++; if (m_wr !== 1'b1 || m_addr !== 8'h30 || m_wdata !== 16'h5A5A) begin failures++; $display("FAIL rw_wr_cmd got=%b/%h/%h exp=1/30/5a5a", m_wr, m_addr, m_wdata); end
    repeat (2) @(negedge clk);
    checks++; if (wr_addr !== 8'h30 || wr_data !== 16'h5A5A) begin failures++; $display("FAIL rw_target_wr got=%h/%h exp=30/5a5a", wr_addr, wr_data); end
    default_reqs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stall();
    int acc0;
    apply_reset();
    set_req(3, 1'b1, 8'h44, 16'h1234);
    m_ready   = 1'b0;
    req_valid = 4'b1000;
    acc0      = acc_cnt;
    #1;
    checks++; if (req_gnt !== 4'b1000) begin failures++; $display("FAIL st_gnt got=%b exp=1000", req_gnt); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) req_valid = 4'b0001;
      #1;
      checks++;
      if (req_gnt !== 4'b0000 || m_sel !== 1'b1 || m_addr !== 8'h44 || m_wdata !== 16'h1234) begin
        failures++;
        $display("FAIL st_hold k=%0d got=%b/%b/%h/%h exp=0000/1/44/1234", k, req_gnt, m_sel, m_addr, m_wdata);
      end
    end
    checks++; if (acc_cnt !== acc0) begin failures++; $display("FAIL st_no_accept got=%0d exp=%0d", acc_cnt, acc0); end
    @(negedge clk);
    m_ready = 1'b1;
    #1;
    checks++; if (req_gnt !== 4'b0001) begin failures++; $display("FAIL st_gnt_on_accept got=%b exp=0001", req_gnt); end
    @(negedge clk);
    req_valid = '0;
    checks++; if (m_addr !== 8'h20 || acc_cnt !== acc0 + 1 || wr_data !== 16'h1234) begin failures++; $display("FAIL st_after got=%h/%0d/%h exp=20/%0d/1234", m_addr, acc_cnt, wr_data, acc0 + 1); end
    default_reqs();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    apply_reset();
    set_req(1, 1'b0, 8'h10, 16'h0000);
    req_valid = 4'b0010;
    #1;
    checks++; if (req_gnt !== 4'b0010) begin failures++; $display("FAIL rmr_gnt got=%b exp=0010", req_gnt); end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    checks++; if (m_sel !== 1'b1) begin failures++; $display("FAIL rmr_rdwait_sel got=%b exp=1", m_sel); end
    rstn = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 4'b0000 || m_sel !== 1'b0) begin failures++; $display("FAIL rmr_abort got=%b/%b exp=0000/0", rsp_valid, m_sel); end
    default_reqs();
    rstn      = 1'b1;
    req_valid = 4'hF;
    #1;
    checks++; if (req_gnt !== 4'b0001) begin failures++; $display("FAIL rmr_ptr_reset got=%b exp=0001", req_gnt); end
    @(negedge clk);
    req_valid = '0;
    checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL rmr_no_late_rsp got=%b exp=0000", rsp_valid); end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn      = 1'b0;
    req_valid = '0;
    req_wr    = '0;
    req_addr  = '0;
    req_wdata = '0;
    m_ready   = 1'b1;
    default_reqs();
    test_reset();
    test_round_robin();
    test_read();
    test_read_then_write();
    test_stall();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
